bcd_disp_mux: RTL and testbench

BCD_DISP_MUX -- requirements
Module: bcd_disp_mux

---
 rtl/bcd_disp_mux.sv | 146 ++++++++++++++
 tb/tb_bcd_disp_mux.sv | 147 ++++++++++++++
 2 files changed

// File: rtl/bcd_disp_mux.sv
// Three-digit BCD 7-segment scan multiplexer: double-buffered digits, guard band, leading-zero blanking.
// seg/an lag the scan state by one cycle; load is always accepted (last write wins) and never stalls.
module bcd_disp_mux #(
    parameter int CLK_DIV    = 50000,
    parameter int GUARD      = 16,
    parameter bit ACTIVE_LOW = 1'b1
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       load,
    input  logic [3:0] ones,
    input  logic [3:0] tens,
    input  logic [3:0] hundreds,
    input  logic       blank_lz,
    output logic [6:0] seg,
    output logic [2:0] an,
    output logic       pending,
    output logic       ack
);

    localparam int CW = $clog2(CLK_DIV);

    typedef enum logic [1:0] {
        DIG0 = 2'd0,
        DIG1 = 2'd1,
        DIG2 = 2'd2
    } state_t;

    state_t        state_q, state_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic [11:0]   shadow_q, shadow_d;
    logic [11:0]   disp_q, disp_d;
    logic          pending_q, pending_d;
    logic          ack_q, ack_d;
    logic [6:0]    seg_q, seg_d;
    logic [2:0]    an_q, an_d;

    logic          last;
    logic          xfer;
    logic [3:0]    digit;
    logic [2:0]    an_sel;
    logic          blank;
    logic [6:0]    seg_raw;
    logic [2:0]    an_raw;

    function automatic logic [6:0] dec7(input logic [3:0] d);
        logic [6:0] s;
        case (d)
            4'd0:    s = 7'h3F;
            4'd1:    s = 7'h06;
            4'd2:    s = 7'h5B;
            4'd3:    s = 7'h4F;
            4'd4:    s = 7'h66;
            4'd5:    s = 7'h6D;
            4'd6:    s = 7'h7D;
            4'd7:    s = 7'h07;
            4'd8:    s = 7'h7F;
            4'd9:    s = 7'h6F;
            default: s = 7'h40;
        endcase
        return s;
    endfunction

    always_comb begin
        last    = (cnt_q == CW'(CLK_DIV - 1));
        cnt_d   = last ? '0 : cnt_q + CW'(1);
        state_d = state_q;
        if (last) begin
            case (state_q)
                DIG0:    state_d = DIG1;
                DIG1:    state_d = DIG2;
                default: state_d = DIG0;
            endcase
        end
    end

    // Transfer only at the very end of a frame so a frame never mixes old and new digits.
    always_comb begin
        xfer      = (state_q == DIG2) && last && pending_q;
        shadow_d  = shadow_q;
        disp_d    = disp_q;
        pending_d = pending_q;
        ack_d     = 1'b0;
        if (xfer) begin
            disp_d    = shadow_q;
            pending_d = 1'b0;
            ack_d     = 1'b1;
        end
        if (load) begin
            shadow_d  = {hundreds, tens, ones};
            pending_d = 1'b1;
        end
    end

    always_comb begin
        case (state_q)
            DIG0: begin
                digit  = disp_q[3:0];
                an_sel = 3'b001;
                blank  = 1'b0;
            end
            DIG1: begin
                digit  = disp_q[7:4];
                an_sel = 3'b010;
                blank  = blank_lz && (disp_q[11:8] == 4'd0) && (disp_q[7:4] == 4'd0);
            end
            default: begin
                digit  = disp_q[11:8];
                an_sel = 3'b100;
                blank  = blank_lz && (disp_q[11:8] == 4'd0);
            end
        endcase
        seg_raw = blank ? 7'h00 : dec7(digit);
        an_raw  = (cnt_q < CW'(GUARD)) ? 3'b000 : an_sel;
        seg_d   = ACTIVE_LOW ? ~seg_raw : seg_raw;
        an_d    = ACTIVE_LOW ? ~an_raw : an_raw;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= DIG0;
            cnt_q     <= '0;
            shadow_q  <= '0;
            disp_q    <= '0;
            pending_q <= 1'b0;
            ack_q     <= 1'b0;
            seg_q     <= {7{ACTIVE_LOW}};
            an_q      <= {3{ACTIVE_LOW}};
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            shadow_q  <= shadow_d;
            disp_q    <= disp_d;
            pending_q <= pending_d;
            ack_q     <= ack_d;
            seg_q     <= seg_d;
            an_q      <= an_d;
        end
    end

    assign seg     = seg_q;
    assign an      = an_q;
    assign pending = pending_q;
    assign ack     = ack_q;

endmodule

// File: tb/tb_bcd_disp_mux.sv
// Directed bench for bcd_disp_mux with CLK_DIV=4, GUARD=1, active-high outputs.
module tb_bcd_disp_mux;

    logic       clk;
    logic       rst;
    logic       load;
    logic [3:0] ones;
    logic [3:0] tens;
    logic [3:0] hundreds;
    logic       blank_lz;
    logic [6:0] seg;
    logic [2:0] an;
    logic       pending;
    logic       ack;

    int checks   = 0;
    int failures = 0;
    logic pend_m = 1'b0;

    bcd_disp_mux #(
        .CLK_DIV    (4),
        .GUARD      (1),
        .ACTIVE_LOW (1'b0)
    ) dut (
        .clk      (clk),
        .rst      (rst),
        .load     (load),
        .ones     (ones),
        .tens     (tens),
        .hundreds (hundreds),
        .blank_lz (blank_lz),
        .seg      (seg),
        .an       (an),
        .pending  (pending),
        .ack      (ack)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, checks=%0d", checks);
        $fatal(1, "watchdog expired");
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [7:0] got, input logic [7:0] exp);
        checks++;
        assert (got === exp) else begin
            failures++;
            $error("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    // One 12-cycle frame from slot DIG0/count 0; s0/s1/s2 are the expected ones/tens/hundreds
    // patterns, la/lb are the frame cycles (or -1) carrying a load of da/db ({h,t,o}).
    task automatic frame(input string tag, input logic [6:0] s0, input logic [6:0] s1,
                         input logic [6:0] s2, input int la, input logic [11:0] da,
                         input int lb, input logic [11:0] db);
        logic       pend_before;
        logic [2:0] an_exp;
        logic [6:0] seg_exp;
        pend_before = 1'b0;
        for (int j = 0; j < 12; j++) begin
            if (j == la) begin
                load = 1'b1;
                {hundreds, tens, ones} = da;
            end else if (j == lb) begin
                load = 1'b1;
                {hundreds, tens, ones} = db;
            end else begin
                load = 1'b0;
            end
            if (j == 11) pend_before = pend_m;
            tick();
            if (j == la || j == lb) pend_m = 1'b1;
            else if (j == 11) pend_m = 1'b0;
            an_exp  = (j % 4 == 0) ? 3'b000 : (3'b001 << (j / 4));
            seg_exp = (j / 4 == 0) ? s0 : ((j / 4 == 1) ? s1 : s2);
            chk($sformatf("%s j%0d an", tag, j), {5'b0, an}, {5'b0, an_exp});
            chk($sformatf("%s j%0d ack", tag, j), {7'b0, ack}, {7'b0, (j == 11) && pend_before});
            chk($sformatf("%s j%0d pending", tag, j), {7'b0, pending}, {7'b0, pend_m});
            if (an_exp != 3'b000)
                chk($sformatf("%s j%0d seg", tag, j), {1'b0, seg}, {1'b0, seg_exp});
        end
        load = 1'b0;
    endtask

    initial begin
        rst      = 1'b1;
        load     = 1'b1;
        {hundreds, tens, ones} = 12'h999;
        blank_lz = 1'b0;
        repeat (3) tick();
        chk("reset seg", {1'b0, seg}, 8'h00);
        chk("reset an", {5'b0, an}, 8'h00);
        chk("reset pending", {7'b0, pending}, 8'h00);
        chk("reset ack", {7'b0, ack}, 8'h00);
        load = 1'b0;
        rst  = 1'b0;
        pend_m = 1'b0;

        // Power-up scan of zeros, load 123 early in DIG0.
        frame("A", 7'h3F, 7'h3F, 7'h3F, 1, 12'h123, -1, 12'h000);
        frame("B", 7'h4F, 7'h5B, 7'h06, -1, 12'h000, -1, 12'h000);
        frame("C", 7'h4F, 7'h5B, 7'h06, 3, 12'h007, -1, 12'h000);
        blank_lz = 1'b1;
        frame("D", 7'h07, 7'h00, 7'h00, 5, 12'h050, -1, 12'h000);
        // Two loads in one frame: only the last survives, one ack.
        frame("E", 7'h3F, 7'h6D, 7'h00, 2, 12'h999, 6, 12'h456);
        // Load on the transfer cycle itself.
        frame("F", 7'h7D, 7'h6D, 7'h66, 4, 12'h301, 11, 12'h108);
        frame("G", 7'h06, 7'h3F, 7'h4F, -1, 12'h000, -1, 12'h000);
        frame("H", 7'h7F, 7'h3F, 7'h06, -1, 12'h000, -1, 12'h000);

        // Reset in the middle of DIG1 with a load pending.
        load = 1'b1;
        {hundreds, tens, ones} = 12'h777;
        tick();
        load = 1'b0;
        chk("midrst pending before", {7'b0, pending}, 8'h01);
        repeat (5) tick();
        chk("midrst an before", {5'b0, an}, 8'h02);
        chk("midrst pending dig1", {7'b0, pending}, 8'h01);
        rst = 1'b1;
        tick();
        chk("midrst seg", {1'b0, seg}, 8'h00);
        chk("midrst an", {5'b0, an}, 8'h00);
        chk("midrst pending", {7'b0, pending}, 8'h00);
        chk("midrst ack", {7'b0, ack}, 8'h00);
        rst = 1'b0;
        pend_m = 1'b0;
        blank_lz = 1'b0;
        frame("I", 7'h3F, 7'h3F, 7'h3F, 7, 12'h01C, -1, 12'h000);
        blank_lz = 1'b1;
        frame("J", 7'h40, 7'h06, 7'h00, -1, 12'h000, -1, 12'h000);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
